// File: rtl/wb_seq_ctrl_pkg.sv
// Shared definitions for the writeback sequencer: mux-select encodings,
// FSM state type and the select-sanitising helper.
package wb_seq_ctrl_pkg;

    localparam logic [2:0] WB_ALU    = 3'b000;
    localparam logic [2:0] WB_LOAD   = 3'b001;
    localparam logic [2:0] WB_IMM    = 3'b010;
    localparam logic [2:0] WB_IADDER = 3'b011;
    localparam logic [2:0] WB_PC4    = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD_WAIT = 2'd1,
        ST_COMMIT    = 2'd2
    } wb_state_t;

    // Unused select codes fall back to the ALU result.
    function automatic logic [2:0] map_sel(input logic [2:0] sel);
        case (sel)
            WB_LOAD, WB_IMM, WB_IADDER, WB_PC4: map_sel = sel;
            default:                            map_sel = WB_ALU;
        endcase
    endfunction

endpackage

// File: rtl/wb_load_timer.sv
// Cycle counter for the load wait: clear has priority over enable,
// tc is high while the count equals TC_VALUE.
module wb_load_timer #(
    parameter int unsigned W        = 8,
    parameter int unsigned TC_VALUE = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == W'(TC_VALUE));

endmodule

// File: rtl/wb_seq_ctrl.sv
// Writeback sequencer: captures a MEM-stage op, waits for load data when
// needed, and issues a single register-file write strobe per committed op.
module wb_seq_ctrl
    import wb_seq_ctrl_pkg::*;
#(
    parameter int unsigned LOAD_TIMEOUT = 16
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       instr_valid_in,
    output logic       instr_ready_out,
    input  logic [2:0] wb_mux_sel_in,
    input  logic [4:0] rd_addr_in,
    input  logic       rf_wr_en_in,
    input  logic       load_valid_in,
    input  logic       flush_in,
    output logic [2:0] wb_mux_sel_reg_out,
    output logic [4:0] rd_addr_reg_out,
    output logic       rf_wr_en_out,
    output logic       load_timeout_out,
    output logic       busy_out,
    output logic [1:0] state_dbg_out
);

    // Handshake: an op transfers on a rising edge where instr_valid_in and
    // instr_ready_out are both high; the op fields must be stable in that cycle.

    wb_state_t state, state_next;
    logic      wr_en_q;
    logic      accept;
    logic      timer_en;
    logic      timer_tc;

    assign accept = instr_valid_in & instr_ready_out;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wb_mux_sel_reg_out <= WB_ALU;
            rd_addr_reg_out    <= '0;
            wr_en_q            <= 1'b0;
        end else if (accept) begin
            wb_mux_sel_reg_out <= map_sel(wb_mux_sel_in);
            rd_addr_reg_out    <= rd_addr_in;
            wr_en_q            <= rf_wr_en_in;
        end
    end

    always_comb begin
        state_next       = state;
        instr_ready_out  = 1'b0;
        rf_wr_en_out     = 1'b0;
        load_timeout_out = 1'b0;
        timer_en         = 1'b0;
        case (state)
            ST_IDLE: begin
                instr_ready_out = ~flush_in;
                if (instr_valid_in && !flush_in) begin
                    state_next = (map_sel(wb_mux_sel_in) == WB_LOAD) ? ST_LOAD_WAIT : ST_COMMIT;
                end
            end
            ST_LOAD_WAIT: begin
                // Flush beats a response, and a response beats the timeout.
                if (flush_in) begin
                    state_next = ST_IDLE;
                end else if (load_valid_in) begin
                    state_next = ST_COMMIT;
                end else if (timer_tc) begin
                    state_next       = ST_IDLE;
                    load_timeout_out = 1'b1;
                end else begin
                    timer_en = 1'b1;
                end
            end
            ST_COMMIT: begin
                state_next   = ST_IDLE;
                rf_wr_en_out = ~flush_in & wr_en_q & (rd_addr_reg_out != 5'd0);
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Counter runs only while staying in LOAD_WAIT, so it is zero on entry.
    wb_load_timer #(
        .W        (8),
        .TC_VALUE (LOAD_TIMEOUT - 1)
    ) u_load_timer (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .clr   (~timer_en),
        .en    (timer_en),
        .tc    (timer_tc)
    );

    assign busy_out      = (state != ST_IDLE);
    assign state_dbg_out = state;

endmodule

// File: tb/tb_wb_seq_ctrl.sv
// Directed bench for wb_seq_ctrl with expected-write and expected-timeout
// queues checked by a negedge monitor.
module tb_wb_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] sel;
    logic [4:0] rd;
    logic       wr_en;
    logic       load_valid;
    logic       flush;
    logic [2:0] sel_reg;
    logic [4:0] rd_reg;
    logic       rf_wr_en;
    logic       load_timeout;
    logic       busy;
    logic [1:0] state_dbg;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Entry layout: {cycle[15:0], sel[2:0], rd[4:0]}
    logic [23:0] exp_q[$];
    logic [15:0] to_q[$];

    wb_seq_ctrl #(.LOAD_TIMEOUT(16)) dut (
        .clk_in             (clk),
        .rst_n_in           (rst_n),
        .instr_valid_in     (instr_valid),
        .instr_ready_out    (instr_ready),
        .wb_mux_sel_in      (sel),
        .rd_addr_in         (rd),
        .rf_wr_en_in        (wr_en),
        .load_valid_in      (load_valid),
        .flush_in           (flush),
        .wb_mux_sel_reg_out (sel_reg),
        .rd_addr_reg_out    (rd_reg),
        .rf_wr_en_out       (rf_wr_en),
        .load_timeout_out   (load_timeout),
        .busy_out           (busy),
        .state_dbg_out      (state_dbg)
    );

    // Clock and cycle count
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every write strobe and timeout pulse must match a queued expectation.
    always @(negedge clk) begin
        logic [23:0] got, want;
        logic [15:0] t;
        if (rf_wr_en) begin
            total++;
            got = {16'(cyc), sel_reg, rd_reg};
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: cyc=%0d sel=%0d rd=%0d, none expected", cyc, sel_reg, rd_reg);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    bad++;
                    $display("FAIL write: got cyc=%0d sel=%0d rd=%0d, want cyc=%0d sel=%0d rd=%0d",
                             got[23:8], got[7:5], got[4:0], want[23:8], want[7:5], want[4:0]);
                end
            end
        end
        if (load_timeout) begin
            total++;
            if (to_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_timeout: cyc=%0d, none expected", cyc);
            end else begin
                t = to_q.pop_front();
                if (16'(cyc) !== t) begin
                    bad++;
                    $display("FAIL timeout: got cyc=%0d, want cyc=%0d", cyc, t);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one op for a single cycle; returns the cycle it was driven in.
    task automatic issue(input logic [2:0] s, input logic [4:0] r, input logic w, output int d);
        d           = cyc;
        instr_valid = 1'b1;
        sel         = s;
        rd          = r;
        wr_en       = w;
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic push_wr(input int c, input logic [2:0] s, input logic [4:0] r);
        exp_q.push_back({16'(c), s, r});
    endtask

    // Non-load vectors: sel, rd, wr_en, expected captured sel, expect a write
    typedef struct packed {
        logic [2:0] s;
        logic [4:0] r;
        logic       w;
        logic [2:0] es;
        logic       ew;
    } vec_t;

    vec_t vecs[8] = '{
        '{3'b000, 5'd5,  1'b1, 3'b000, 1'b1},
        '{3'b110, 5'd0,  1'b1, 3'b000, 1'b0},
        '{3'b111, 5'd3,  1'b1, 3'b000, 1'b1},
        '{3'b100, 5'd9,  1'b0, 3'b000, 1'b0},
        '{3'b101, 5'd31, 1'b1, 3'b101, 1'b1},
        '{3'b010, 5'd12, 1'b1, 3'b010, 1'b1},
        '{3'b011, 5'd1,  1'b1, 3'b011, 1'b1},
        '{3'b010, 5'd0,  1'b1, 3'b010, 1'b0}
    };

    initial begin
        int d;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        sel         = '0;
        rd          = '0;
        wr_en       = 1'b0;
        load_valid  = 1'b0;
        flush       = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_sel_reg", sel_reg, 0);
        check("rst_rd_reg", rd_reg, 0);
        check("rst_state", state_dbg, 0);
        check("rst_ready", instr_ready, 1);
        tick();
        rst_n = 1'b1;
        tick();

        // Basic ALU op: busy for exactly one cycle
        issue(3'b000, 5'd5, 1'b1, d);
        push_wr(d + 1, 3'b000, 5'd5);
        @(negedge clk);
        check("alu_busy_commit", busy, 1);
        check("alu_state_commit", state_dbg, 2);
        check("alu_ready_commit", instr_ready, 0);
        tick();
        @(negedge clk);
        check("alu_busy_after", busy, 0);
        tick();

        // Non-load select table, including sanitised codes and rd=0
        foreach (vecs[i]) begin
            issue(vecs[i].s, vecs[i].r, vecs[i].w, d);
            if (vecs[i].ew) push_wr(d + 1, vecs[i].es, vecs[i].r);
            tick();
            @(negedge clk);
            check($sformatf("vec%0d_sel_reg", i), sel_reg, vecs[i].es);
            check($sformatf("vec%0d_rd_reg", i), rd_reg, vecs[i].r);
            check($sformatf("vec%0d_idle", i), busy, 0);
            tick();
        end

        // Load with response three cycles after the op is driven
        issue(3'b001, 5'd7, 1'b1, d);
        tick();
        tick();
        load_valid = 1'b1;
        push_wr(d + 4, 3'b001, 5'd7);
        tick();
        load_valid = 1'b0;
        @(negedge clk);
        check("load_sel_reg", sel_reg, 1);
        tick();
        tick();

        // Load with no response: timeout pulse, no write
        issue(3'b001, 5'd8, 1'b1, d);
        to_q.push_back(16'(d + 16));
        @(negedge clk);
        check("load_wait_state", state_dbg, 1);
        repeat (18) tick();
        @(negedge clk);
        check("timeout_idle", busy, 0);
        tick();

        // Response arrives on the terminal count cycle: response wins
        issue(3'b001, 5'd9, 1'b1, d);
        repeat (15) tick();
        load_valid = 1'b1;
        push_wr(d + 17, 3'b001, 5'd9);
        tick();
        load_valid = 1'b0;
        tick();
        tick();

        // Flush together with the load response
        issue(3'b001, 5'd10, 1'b1, d);
        tick();
        flush      = 1'b1;
        load_valid = 1'b1;
        tick();
        flush      = 1'b0;
        load_valid = 1'b0;
        @(negedge clk);
        check("flush_load_idle", busy, 0);
        repeat (20) tick();

        // Flush during COMMIT suppresses the write
        issue(3'b000, 5'd4, 1'b1, d);
        flush = 1'b1;
        @(negedge clk);
        check("flush_commit_wr", rf_wr_en, 0);
        tick();
        // Flush in IDLE blocks acceptance
        instr_valid = 1'b1;
        sel         = 3'b000;
        rd          = 5'd11;
        @(negedge clk);
        check("flush_ready", instr_ready, 0);
        tick();
        instr_valid = 1'b0;
        flush       = 1'b0;
        @(negedge clk);
        check("flush_no_accept", busy, 0);
        tick();

        // Load response while idle is ignored
        load_valid = 1'b1;
        tick();
        tick();
        load_valid = 1'b0;
        @(negedge clk);
        check("stray_load_idle", busy, 0);
        tick();

        // Asynchronous reset mid-load, then immediate accept after release
        issue(3'b001, 5'd13, 1'b1, d);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("async_busy", busy, 0);
        check("async_sel_reg", sel_reg, 0);
        check("async_rd_reg", rd_reg, 0);
        check("async_wr", rf_wr_en, 0);
        check("async_timeout", load_timeout, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        check("post_rst_ready", instr_ready, 1);
        issue(3'b000, 5'd6, 1'b1, d);
        push_wr(d + 1, 3'b000, 5'd6);
        repeat (20) tick();

        check("exp_q_empty", exp_q.size(), 0);
        check("to_q_empty", to_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_seq_ctrl.md
WB_SEQ_CTRL -- requirements
Module: wb_seq_ctrl

Interface
REQ-001 Parameter: LOAD_TIMEOUT, default 16, max cycles in LOAD_WAIT before abort (range 2..255).
REQ-002 clk_in  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n_in  input  1  reset; asynchronous assert, active-low.
REQ-004 instr_valid_in  input  1  upstream MEM stage presents a writeback op.
REQ-005 instr_ready_out  output  1  block can accept an op this cycle.
REQ-006 wb_mux_sel_in  input  3  writeback source select (000 ALU, 001 load, 010 imm, 011 iadder, 101 pc+4).
REQ-007 rd_addr_in  input  5  destination register.
REQ-008 rf_wr_en_in  input  1  op writes the register file.
REQ-009 load_valid_in  input  1  data-memory load response valid.
REQ-010 flush_in  input  1  pipeline flush; kills any op in flight.
REQ-011 wb_mux_sel_reg_out  output  3  registered select driving the writeback mux.
REQ-012 rd_addr_reg_out  output  5  registered destination register.
REQ-013 rf_wr_en_out  output  1  register-file write strobe, one cycle per committed op.
REQ-014 load_timeout_out  output  1  one-cycle pulse on load abort.
REQ-015 busy_out  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states SHALL be IDLE, LOAD_WAIT, COMMIT.
REQ-017 instr_ready_out SHALL be 1 only in IDLE with flush_in=0.
REQ-018 Accept = instr_valid_in & instr_ready_out; on accept, sel, rd, wr_en SHALL be captured into the _reg_out registers.
REQ-019 On accept: sel=001 -> LOAD_WAIT; any other sel -> COMMIT.
REQ-020 Sel codes 100, 110, 111 SHALL be captured as 000 (ALU result).
REQ-021 In LOAD_WAIT a timeout counter SHALL increment each cycle from 0; load_valid_in=1 -> COMMIT.
REQ-022 Counter reaching LOAD_TIMEOUT-1 with load_valid_in=0 -> IDLE, load_timeout_out=1 for that one transition cycle, no register write.
REQ-023 load_valid_in and timeout in the same cycle: response wins, go to COMMIT.
REQ-024 COMMIT SHALL last exactly one cycle: rf_wr_en_out = captured wr_en & (rd != 0), then -> IDLE.
REQ-025 Latency: non-load op writes in the cycle after accept; load op writes in the cycle after load_valid_in.
REQ-026 load_valid_in outside LOAD_WAIT SHALL be ignored.
REQ-027 flush_in=1 in LOAD_WAIT or COMMIT SHALL force IDLE next cycle, rf_wr_en_out=0 that cycle, no timeout pulse, counter cleared.
REQ-028 wb_mux_sel_reg_out and rd_addr_reg_out SHALL hold their value outside accept.

Reset
REQ-029 While rst_n_in=0: state IDLE, counter 0, wb_mux_sel_reg_out 000, rd_addr_reg_out 0, rf_wr_en_out 0, load_timeout_out 0, busy_out 0.
REQ-030 Reset mid-load SHALL discard the op without write or timeout pulse; first accept is possible the cycle after deassertion.

Structure
REQ-031 Shared package SHALL hold the wb_mux_sel encodings (WB_ALU, WB_LOAD, WB_IMM, WB_IADDER, WB_PC4) and the FSM state typedef.
REQ-032 The timeout counter SHALL be one sub-module, wb_load_timer (clear, enable, terminal-count output).

Verification
REQ-033 Accept sel=000, rd=5, wr_en=1 -> next cycle rf_wr_en_out=1, rd_addr_reg_out=5, sel_reg=000; busy 1 cycle.
REQ-034 Accept sel=001, rd=7, load_valid_in after 3 cycles -> rf_wr_en_out=1 one cycle later, rd=7, sel_reg=001.
REQ-035 Accept load, no response, LOAD_TIMEOUT=16 -> load_timeout_out pulse 16 cycles after accept, rf_wr_en_out never 1, back to IDLE.
REQ-036 Accept sel=110, rd=0, wr_en=1 -> sel_reg=000, rf_wr_en_out stays 0.
REQ-037 Load in LOAD_WAIT, flush_in=1 same cycle as load_valid_in -> IDLE, no write, no timeout pulse.
REQ-038 rst_n_in low mid-LOAD_WAIT -> all outputs reset values immediately (async), instr_ready_out=1 first cycle after release.
